ah_mul_pipelined: RTL and testbench
===================================

# ah_mul_pipelined

Fully pipelined signed two's-complement multiplier built as the inverse of the pipelined restoring divider: one shift-and-add stage per multiplier bit, throughput one operation per clock. It reconstructs products (for example quotient × divisor for remainder or check paths) in the arithmetic library alongside the divider. It uses the same sign-magnitude front end, per-bit stage structure, `start`/`data_valid` sideband and zero-operand flag as the divider.

## Interface
- `WIDTH`, default 16: operand width in bits (≥ 2). The pipeline has WIDTH add stages.
- `clk`  input  1: clock. All registers update on the rising edge.
- `rst_n`  input  1: reset, asynchronous, active-low.
- `start`  input  1: the operands on this cycle are a valid operation; sampled every rising edge.
- `multiplicand`  input  WIDTH: signed two's-complement operand A.
- `multiplier`  input  WIDTH: signed two's-complement operand B.
- `product`  output  2*WIDTH: signed two's-complement A×B; meaningful when `data_valid`=1.
- `data_valid`  output  1: `product` and `zero_operand` belong to an operation that was issued with `start`=1.
- `zero_operand`  output  1: A==0 or B==0 for the operation being presented.

## Operation
- **Capture stage (S0):**
  - register `v0`=start and `neg0`=A[W-1]^B[W-1].
  - register `zero0`=(A==0)|(B==0).
  - register `amag`=|A| and `bmag`=|B|, each as an unsigned WIDTH-bit value; |−2^(W−1)| = 2^(W−1) fits exactly.
  - clear the partial product `pp0`=0, which is 2*WIDTH bits unsigned.
- **Add stage k (k=0..WIDTH-1):**
  - `pp(k+1)` = `pp(k)` + (`bmag`[k] ? {amag}<<k : 0), computed in 2*WIDTH bits.
  - forward `amag`, `bmag`, valid, neg and zero unchanged.
  - No carry out of 2*WIDTH bits is possible.
- **Output stage:**
  - `data_valid` <= v(final) on every edge.
  - Only when v(final)=1: `product` <= neg ? (~pp+1) : pp, and `zero_operand` <= zero.
  - When v(final)=0, `product` and `zero_operand` hold their last valid values.
- Bubbles (`start`=0) still advance through the pipeline. Their data is don't-care and never reaches `product`.
- No backpressure and no stall: every issued operation emerges exactly once, in issue order.
- Sign of a zero result: the negation of 0 is 0, so the output is 0 regardless of the neg flag.
- Full range is exact: (−2^(W−1))×(−2^(W−1)) = 2^(2W−2) is representable.

## Timing
- Reset values (asserted asynchronously, immediately): `product`=0, `data_valid`=0, `zero_operand`=0. All pipeline valid bits are 0 and all data registers are 0.
- Latency is WIDTH+2 rising edges, counting the capture edge.
  - An operation sampled at edge n appears on the outputs after edge n+WIDTH+1.
  - For WIDTH=16: sampled at edge 1, `data_valid`=1 after edge 18.
- Throughput: a new operation may be issued on every edge. `start` held high for N cycles gives `data_valid` high for exactly N consecutive cycles.
- `data_valid` is a single-cycle pulse for an isolated operation.
- Reset asserted mid-stream discards all in-flight operations.
  - No `data_valid` pulse is produced for them after reset release.
  - The first operation after release follows the normal latency.
- `start` asserted during the first edge after reset release is captured normally.

## Test plan
All scenarios use WIDTH=16.
1. **Basic positive:** A=3, B=5, `start` pulsed one cycle -> exactly WIDTH+2=18 edges later `data_valid`=1 for one cycle, `product`=0x0000000F, `zero_operand`=0.
2. **Sign handling:**
   - A=−7 (0xFFF9), B=6 -> `product`=0xFFFFFFD6 (−42).
   - A=−7, B=−6 -> `product`=0x0000002A.
3. **Range extremes:**
   - A=B=0x8000 -> `product`=0x40000000.
   - A=0x7FFF, B=0x8000 -> `product`=0xC0008000.
   - A=B=0x7FFF -> `product`=0x3FFF0001.
4. **Zero operand:** A=0, B=−1234 -> `product`=0x00000000, `zero_operand`=1, `data_valid`=1.
5. **Streaming:**
   - Issue 20 back-to-back random operations, then a bubble, then 5 more -> `data_valid` high for 20 cycles, low for 1, high for 5.
   - Each `product` matches the reference model in order.
   - `product` holds its value during the bubble cycle.
6. **Reset mid-operation:**
   - Issue 8 operations, then assert `rst_n`=0 for 2 cycles while they are in flight -> outputs go to 0 asynchronously, and no `data_valid` appears afterward for those 8.
   - A new operation, 9×9, issued after release returns 0x00000051 with the standard latency.

Source files
------------

// File: rtl/ah_mul_pipelined_if.sv
// Operand/result bundle for the pipelined signed multiplier.
// master drives operands and start; slave returns product, data_valid and zero_operand.
interface ah_mul_pipelined_if #(
  parameter int WIDTH = 16
);
  logic                   start;
  logic [WIDTH-1:0]       multiplicand;
  logic [WIDTH-1:0]       multiplier;
  logic [2*WIDTH-1:0]     product;
  logic                   data_valid;
  logic                   zero_operand;

  modport master (
    output start, multiplicand, multiplier,
    input  product, data_valid, zero_operand
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output product, data_valid, zero_operand
  );
endinterface

// File: rtl/ah_mul_pipelined.sv
// Signed multiplier: sign-magnitude capture, one shift-and-add stage per multiplier bit.
// Latency WIDTH+2 edges, one op per clock; no backpressure, bubbles flow through.
module ah_mul_pipelined #(
  parameter int WIDTH = 16
) (
  input logic              clk,
  input logic              rst_n,
  ah_mul_pipelined_if.slave bus
);
  localparam int PW = 2 * WIDTH;

  logic             v_q    [0:WIDTH];
  logic             neg_q  [0:WIDTH];
  logic             zero_q [0:WIDTH];
  logic [PW-1:0]    pp_q   [0:WIDTH];
  logic [WIDTH-1:0] amag_q [0:WIDTH-1];
  logic [WIDTH-1:0] bmag_q [0:WIDTH-1];

  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;

  // Two's-complement of the most negative value yields 2^(WIDTH-1) as unsigned.
  assign a_abs = bus.multiplicand[WIDTH-1] ? (~bus.multiplicand + WIDTH'(1)) : bus.multiplicand;
  assign b_abs = bus.multiplier[WIDTH-1]   ? (~bus.multiplier   + WIDTH'(1)) : bus.multiplier;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q[0]    <= 1'b0;
      neg_q[0]  <= 1'b0;
      zero_q[0] <= 1'b0;
      pp_q[0]   <= '0;
      amag_q[0] <= '0;
      bmag_q[0] <= '0;
    end else begin
      v_q[0]    <= bus.start;
      neg_q[0]  <= bus.multiplicand[WIDTH-1] ^ bus.multiplier[WIDTH-1];
      zero_q[0] <= (bus.multiplicand == '0) || (bus.multiplier == '0);
      pp_q[0]   <= '0;
      amag_q[0] <= a_abs;
      bmag_q[0] <= b_abs;
    end
  end

  for (genvar k = 0; k < WIDTH; k++) begin : g_stage
    logic [PW-1:0] addend;

    assign addend = bmag_q[k][k] ? (PW'(amag_q[k]) << k) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q[k+1]    <= 1'b0;
        neg_q[k+1]  <= 1'b0;
        zero_q[k+1] <= 1'b0;
        pp_q[k+1]   <= '0;
      end else begin
        v_q[k+1]    <= v_q[k];
        neg_q[k+1]  <= neg_q[k];
        zero_q[k+1] <= zero_q[k];
        pp_q[k+1]   <= pp_q[k] + addend;
      end
    end

    // The final stage has no consumer for the magnitudes.
    if (k < WIDTH - 1) begin : g_fwd
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          amag_q[k+1] <= '0;
          bmag_q[k+1] <= '0;
        end else begin
          amag_q[k+1] <= amag_q[k];
          bmag_q[k+1] <= bmag_q[k];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.data_valid   <= 1'b0;
      bus.product      <= '0;
      bus.zero_operand <= 1'b0;
    end else begin
      bus.data_valid <= v_q[WIDTH];
      if (v_q[WIDTH]) begin
        bus.product      <= neg_q[WIDTH] ? (~pp_q[WIDTH] + PW'(1)) : pp_q[WIDTH];
        bus.zero_operand <= zero_q[WIDTH];
      end
    end
  end
endmodule

// File: tb/tb_ah_mul_pipelined.sv
// Directed and streaming checks of ah_mul_pipelined against a queue of expected results.
// Every output edge is checked for value, zero flag, latency and hold-on-idle behaviour.
module tb_ah_mul_pipelined;
  localparam int W   = 16;
  localparam int LAT = W + 1;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_errors;

  typedef struct {
    logic [2*W-1:0] p;
    logic           z;
    int             iss;
  } exp_t;

  exp_t           exp_q[$];
  logic [2*W-1:0] last_p;
  logic           last_z;

  ah_mul_pipelined_if #(.WIDTH(W)) bus ();

  ah_mul_pipelined #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Outputs sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (bus.data_valid === 1'b1) begin
      chk("valid_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("product", 64'(bus.product), 64'(e.p));
        chk("zero_operand", 64'(bus.zero_operand), 64'(e.z));
        chk("latency", 64'(cyc - e.iss), 64'(LAT));
        last_p = e.p;
        last_z = e.z;
      end
    end else begin
      chk("product_hold", 64'(bus.product), 64'(last_p));
      chk("zero_hold", 64'(bus.zero_operand), 64'(last_z));
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] p, input logic z);
    exp_t e;
    bus.start        = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    e.p = p;
    e.z = z;
    e.iss = cyc + 1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.start        = 1'b0;
    bus.multiplicand = $urandom();
    bus.multiplier   = $urandom();
  endtask

  task automatic issue_rand();
    logic signed [W-1:0]   a;
    logic signed [W-1:0]   b;
    logic signed [2*W-1:0] p;
    a = W'($urandom());
    b = W'($urandom());
    p = a * b;
    issue(a, b, p, (a == 0) || (b == 0));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
    idle(4);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    last_p   = '0;
    last_z   = 1'b0;
    rst_n    = 1'b0;
    bus.start        = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    idle(2);
    chk("reset_product", 64'(bus.product), 64'd0);
    chk("reset_valid", 64'(bus.data_valid), 64'd0);
    chk("reset_zero", 64'(bus.zero_operand), 64'd0);
    rst_n = 1'b1;
    idle(1);

    issue(16'd3, 16'd5, 32'h0000000F, 1'b0);
    drain();
    issue(16'hFFF9, 16'd6, 32'hFFFFFFD6, 1'b0);
    issue(16'hFFF9, 16'hFFFA, 32'h0000002A, 1'b0);
    drain();
    issue(16'h0000, 16'hFB2E, 32'h00000000, 1'b1);
    drain();
    issue(16'h8000, 16'h8000, 32'h40000000, 1'b0);
    issue(16'h7FFF, 16'h8000, 32'hC0008000, 1'b0);
    issue(16'h7FFF, 16'h7FFF, 32'h3FFF0001, 1'b0);
    drain();

    // Eight ops in flight, then reset; none of them may emerge.
    for (int i = 0; i < 8; i++) issue_rand();
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    last_p = '0;
    last_z = 1'b0;
    #1;
    chk("async_rst_product", 64'(bus.product), 64'd0);
    chk("async_rst_valid", 64'(bus.data_valid), 64'd0);
    chk("async_rst_zero", 64'(bus.zero_operand), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(16'd9, 16'd9, 32'h00000051, 1'b0);
    drain();
    idle(LAT);

    for (int i = 0; i < 20; i++) issue_rand();
    idle(1);
    for (int i = 0; i < 5; i++) issue_rand();
    drain();
    idle(LAT);
    chk("final_pending", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
